fir_seq_controller: RTL and testbench
=====================================

Name: fir_seq_controller

Overview:
- Parametrised sequencing controller for the N-tap FIR datapath.
- Steps a shared register-file/ALU datapath through three phases:
  - sample store
  - sample shift
  - per-tap multiply/accumulate, with a per-tap add/subtract sign mask
- Also handles an N-step coefficient-load handshake.
- Sits between the input interface (dr, lc) and the register-file/ALU datapath. Drives the operand/destination addresses, the opcode and the status flags.

Parameters:
- NUM_TAPS, 4: number of filter taps N. Legal range 2..6 with ADDR_W=4; in general 2*N+2 must be < 2^ADDR_W.
- ADDR_W, 4: register-file address width.
- SIGN_MASK, 4'b1010: NUM_TAPS bits. Bit k=1 means tap k's product is subtracted from the accumulator; bit k=0 means it is added.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- dr  in  1  new sample ready; must stay high through STORE
- lc  in  1  load-coefficient strobe
- overflow  in  1  ALU overflow flag for the current operation
- cnt_up  out  1  one-cycle pulse per processed sample
- clear  out  1  high during coefficient-load phase
- modwait  out  1  registered busy flag
- op  out  3  ALU opcode: 000 NOP, 001 COPY, 010 LOAD_SAMPLE, 011 LOAD_COEF, 100 ADD, 101 SUB, 110 MUL
- src1  out  ADDR_W  operand-1 register
- src2  out  ADDR_W  operand-2 register
- dest  out  ADDR_W  destination register
- err  out  1  error status
- tap_idx  out  3  current tap or coefficient index (0..N-1); for debug and scoreboard

Behaviour:
- Register map:
  - R0: accumulator
  - R1..RN: sample history (R1 oldest)
  - R(N+1): incoming sample
  - R(N+2+k): coefficient k
  - R(2N+2): product temp T
- Internal state:
  - State register plus index counter k (3 bits).
  - modwait is registered from next_modwait.
  - All other outputs are combinational from state, k and inputs.
  - Outputs not listed for a state are 0.
- Reset (async, n_rst=0): state=IDLE, k=0, modwait=0. All outputs therefore 0.
- IDLE:
  - next_modwait=0.
  - lc -> LOAD with k=0; else dr -> STORE. lc wins if both are high.
- STORE:
  - dest=N+1, op=010, next_modwait=1.
  - dr low -> EIDLE; else -> ZERO.
- ZERO:
  - src1=src2=dest=0, op=101, cnt_up=1.
  - k<=1, -> SHIFT.
- SHIFT:
  - src1=k+1, dest=k, op=001.
  - k==N -> MUL with k<=0; else k<=k+1.
- MUL:
  - src1=k+1, src2=N+2+k, dest=2N+2, op=110.
  - overflow -> EIDLE; else -> ACC.
- ACC:
  - src1=0, src2=2N+2, dest=0.
  - op=101 if SIGN_MASK[k], else 100.
  - overflow -> EIDLE.
  - Else if k==N-1 -> IDLE with k<=0; else k<=k+1 and -> MUL.
- EIDLE:
  - err=1, next_modwait=0.
  - lc -> LOAD with k=0; else dr -> STORE.
  - err clears combinationally on leaving EIDLE.
- LOAD:
  - dest=N+2+k, op=011, clear=1, next_modwait=1.
  - k==N-1 -> IDLE with k<=0; else -> WAIT with k<=k+1.
- WAIT:
  - clear=1, next_modwait=0.
  - lc -> LOAD; dr is ignored.
- modwait timing:
  - Rises the cycle after STORE or LOAD is entered.
  - Falls the cycle after IDLE, EIDLE or WAIT is entered.
- Sample latency: STORE to IDLE is 3N+2 cycles (14 for N=4). modwait is high for 3N+2 cycles.
- Overflow is honoured only in MUL and ACC; it is ignored elsewhere.
- dr and lc are ignored in ZERO, SHIFT, MUL, ACC and LOAD.
- Reset mid-sequence returns to IDLE immediately, with k=0 and modwait=0.
- tap_idx = k in all states.

Test Plan:
1. Reset, then a 1-cycle dr pulse (dr low in STORE) -> next state EIDLE; err=1 the following cycle; modwait=1 for exactly one cycle.
2. N=4: lc held for 1 cycle, then 3 more lc strobes each after a ≥2-cycle gap -> dest sequence 6,7,8,9 with op=011 and clear=1 throughout; returns to IDLE with modwait=0.
3. N=4, dr held 2 cycles, no overflow -> 14-cycle sequence:
   - dest: 5, 0, 1, 2, 3, 4, 10, 0, 10, 0, 10, 0, 10, 0
   - ACC ops: 100, 101, 100, 101
   - cnt_up high only in ZERO
4. overflow=1 during the second MUL (k=1) -> next state EIDLE; err=1; modwait falls one cycle later; a subsequent dr restarts cleanly.
5. NUM_TAPS=6, SIGN_MASK=6'b000001 -> temp register 14; coefficients 8..13; first ACC op=101 and the rest 100; latency 20 cycles.
6. n_rst asserted during SHIFT (k=2) -> all outputs 0 asynchronously; after release, a dr-started sequence begins with k=0.

Source files
------------

// File: rtl/fir_seq_controller.sv
// fir_seq_controller: steps a shared register-file/ALU datapath through the
// store / shift / multiply-accumulate phases of an N-tap FIR filter, and
// runs the N-step coefficient-load handshake.
//
// Register map: R0 accumulator, R1..RN sample history (R1 oldest),
// R(N+1) incoming sample, R(N+2+k) coefficient k, R(2N+2) product temp.
module fir_seq_controller #(
  parameter int unsigned         NUM_TAPS  = 4,
  parameter int unsigned         ADDR_W    = 4,
  parameter logic [NUM_TAPS-1:0] SIGN_MASK = 4'b1010
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              err,
  output logic [2:0]        tap_idx
);

  localparam int unsigned K_W = 3;

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_COPY        = 3'b001;
  localparam logic [2:0] OP_LOAD_SAMPLE = 3'b010;
  localparam logic [2:0] OP_LOAD_COEF   = 3'b011;
  localparam logic [2:0] OP_ADD         = 3'b100;
  localparam logic [2:0] OP_SUB         = 3'b101;
  localparam logic [2:0] OP_MUL         = 3'b110;

  localparam logic [ADDR_W-1:0] ADDR_ACC    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_SAMPLE = ADDR_W'(NUM_TAPS + 1);
  localparam logic [ADDR_W-1:0] ADDR_COEF0  = ADDR_W'(NUM_TAPS + 2);
  localparam logic [ADDR_W-1:0] ADDR_TEMP   = ADDR_W'(2 * NUM_TAPS + 2);

  localparam logic [K_W-1:0] K_N    = K_W'(NUM_TAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_TAPS - 1);

  // Mask widened to the full index range so any k value selects a defined bit.
  localparam logic [(1<<K_W)-1:0] SIGN_MASK_EXT = (1<<K_W)'(SIGN_MASK);

  typedef enum logic [3:0] {
    S_IDLE,
    S_STORE,
    S_ZERO,
    S_SHIFT,
    S_MUL,
    S_ACC,
    S_EIDLE,
    S_LOAD,
    S_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic           modwait_q, modwait_d;

  // State, tap index and busy flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      modwait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      modwait_q <= modwait_d;
    end
  end

  // Next-state, index and datapath control decode; busy flag holds unless a state sets it.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    modwait_d = modwait_q;
    cnt_up    = 1'b0;
    clear     = 1'b0;
    err       = 1'b0;
    op        = OP_NOP;
    src1      = '0;
    src2      = '0;
    dest      = '0;

    unique case (state_q)
      S_IDLE: begin
        modwait_d = 1'b0;
        if (lc) begin
          state_d = S_LOAD;
          k_d     = '0;
        end else if (dr) begin
          state_d = S_STORE;
          k_d     = '0;
        end
      end

      S_STORE: begin
        dest      = ADDR_SAMPLE;
        op        = OP_LOAD_SAMPLE;
        modwait_d = 1'b1;
        state_d   = dr ? S_ZERO : S_EIDLE;
      end

      S_ZERO: begin
        src1    = ADDR_ACC;
        src2    = ADDR_ACC;
        dest    = ADDR_ACC;
        op      = OP_SUB;
        cnt_up  = 1'b1;
        k_d     = K_W'(1);
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        src1 = ADDR_W'(k_q) + ADDR_W'(1);
        dest = ADDR_W'(k_q);
        op   = OP_COPY;
        if (k_q == K_N) begin
          state_d = S_MUL;
          k_d     = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end

      S_MUL: begin
        src1    = ADDR_W'(k_q) + ADDR_W'(1);
        src2    = ADDR_COEF0 + ADDR_W'(k_q);
        dest    = ADDR_TEMP;
        op      = OP_MUL;
        state_d = overflow ? S_EIDLE : S_ACC;
      end

      S_ACC: begin
        src1 = ADDR_ACC;
        src2 = ADDR_TEMP;
        dest = ADDR_ACC;
        op   = SIGN_MASK_EXT[k_q] ? OP_SUB : OP_ADD;
        if (overflow) begin
          state_d = S_EIDLE;
        end else if (k_q == K_LAST) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          state_d = S_MUL;
          k_d     = k_q + K_W'(1);
        end
      end

      S_EIDLE: begin
        err       = 1'b1;
        modwait_d = 1'b0;
        // Restart from a clean index whichever way the error is left.
        if (lc) begin
          state_d = S_LOAD;
          k_d     = '0;
        end else if (dr) begin
          state_d = S_STORE;
          k_d     = '0;
        end
      end

      S_LOAD: begin
        dest      = ADDR_COEF0 + ADDR_W'(k_q);
        op        = OP_LOAD_COEF;
        clear     = 1'b1;
        modwait_d = 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else begin
          state_d = S_WAIT;
          k_d     = k_q + K_W'(1);
        end
      end

      S_WAIT: begin
        clear     = 1'b1;
        modwait_d = 1'b0;
        if (lc) begin
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d   = S_IDLE;
        k_d       = '0;
        modwait_d = 1'b0;
      end
    endcase
  end

  assign modwait = modwait_q;
  assign tap_idx = k_q;

endmodule

// File: tb/tb_fir_seq_controller.sv
// tb_fir_seq_controller: directed checks of the FIR sequencing controller
// for a 4-tap (mask 1010) and a 6-tap (mask 000001) configuration.
module tb_fir_seq_controller;

  logic       clk;
  logic       n_rst;
  logic       dr;
  logic       lc;
  logic       overflow;

  logic       a_cnt_up, a_clear, a_modwait, a_err;
  logic [2:0] a_op, a_tap;
  logic [3:0] a_src1, a_src2, a_dest;

  logic       b_cnt_up, b_clear, b_modwait, b_err;
  logic [2:0] b_op, b_tap;
  logic [3:0] b_src1, b_src2, b_dest;

  int vectors;
  int miscompares;

  // Expected per-cycle datapath control for one 4-tap sample (STORE .. last ACC).
  int dest4 [14] = '{5, 0, 1, 2, 3, 4, 10, 0, 10, 0, 10, 0, 10, 0};
  int op4   [14] = '{2, 5, 1, 1, 1, 1, 6, 4, 6, 5, 6, 4, 6, 5};
  int s1_4  [14] = '{0, 0, 2, 3, 4, 5, 1, 0, 2, 0, 3, 0, 4, 0};
  int s2_4  [14] = '{0, 0, 0, 0, 0, 0, 6, 10, 7, 10, 8, 10, 9, 10};
  int tap4  [14] = '{0, 0, 1, 2, 3, 4, 0, 0, 1, 1, 2, 2, 3, 3};

  // Expected per-cycle control for one 6-tap sample.
  int dest6 [20] = '{7, 0, 1, 2, 3, 4, 5, 6, 14, 0, 14, 0, 14, 0, 14, 0, 14, 0, 14, 0};
  int op6   [20] = '{2, 5, 1, 1, 1, 1, 1, 1, 6, 5, 6, 4, 6, 4, 6, 4, 6, 4, 6, 4};
  int s2_6  [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 8, 14, 9, 14, 10, 14, 11, 14, 12, 14, 13, 14};

  fir_seq_controller #(
    .NUM_TAPS (4),
    .ADDR_W   (4),
    .SIGN_MASK(4'b1010)
  ) dut4 (
    .clk     (clk),
    .n_rst   (n_rst),
    .dr      (dr),
    .lc      (lc),
    .overflow(overflow),
    .cnt_up  (a_cnt_up),
    .clear   (a_clear),
    .modwait (a_modwait),
    .op      (a_op),
    .src1    (a_src1),
    .src2    (a_src2),
    .dest    (a_dest),
    .err     (a_err),
    .tap_idx (a_tap)
  );

  fir_seq_controller #(
    .NUM_TAPS (6),
    .ADDR_W   (4),
    .SIGN_MASK(6'b000001)
  ) dut6 (
    .clk     (clk),
    .n_rst   (n_rst),
    .dr      (dr),
    .lc      (lc),
    .overflow(overflow),
    .cnt_up  (b_cnt_up),
    .clear   (b_clear),
    .modwait (b_modwait),
    .op      (b_op),
    .src1    (b_src1),
    .src2    (b_src2),
    .dest    (b_dest),
    .err     (b_err),
    .tap_idx (b_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset holds every output at zero; IDLE after release is also all-zero.
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({a_cnt_up, a_clear, a_modwait, a_err, a_op, a_src1, a_src2, a_dest, a_tap} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
               {a_cnt_up, a_clear, a_modwait, a_err, a_op, a_src1, a_src2, a_dest, a_tap});
    end
    n_rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_cnt_up, a_clear, a_modwait, a_err, a_op, a_dest, a_tap} !== 13'd0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h want 0",
               {a_cnt_up, a_clear, a_modwait, a_err, a_op, a_dest, a_tap});
    end
  endtask

  // A one-cycle dr pulse drops out of STORE into the error state.
  task automatic test_dr_pulse();
    dr = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_dest !== 4'd5 || a_op !== 3'b010 || a_modwait !== 1'b0 || a_err !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_store: dest=%0d op=%0d mw=%0d err=%0d want 5 2 0 0",
               a_dest, a_op, a_modwait, a_err);
    end
    dr = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_err !== 1'b1 || a_modwait !== 1'b1 || a_op !== 3'b000) begin
      miscompares++;
      $display("FAIL pulse_eidle: err=%0d mw=%0d op=%0d want 1 1 0", a_err, a_modwait, a_op);
    end
    @(negedge clk);
    vectors++;
    if (a_err !== 1'b1 || a_modwait !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_mw_fall: err=%0d mw=%0d want 1 0", a_err, a_modwait);
    end
  endtask

  // Four lc strobes with gaps load coefficients 6..9; lc beats dr on the first.
  task automatic test_coef_load();
    lc = 1'b1;
    dr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lc = 1'b0;
      dr = 1'b0;
      vectors++;
      if (a_dest !== 4'(6 + k) || a_op !== 3'b011 || a_clear !== 1'b1 ||
          a_tap !== 3'(k) || a_err !== 1'b0) begin
        miscompares++;
        $display("FAIL load[%0d]: dest=%0d op=%0d clr=%0d tap=%0d err=%0d want %0d 3 1 %0d 0",
                 k, a_dest, a_op, a_clear, a_tap, a_err, 6 + k, k);
      end
      if (k < 3) begin
        @(negedge clk);
        vectors++;
        if (a_clear !== 1'b1 || a_op !== 3'b000 || a_modwait !== 1'b1) begin
          miscompares++;
          $display("FAIL wait1[%0d]: clr=%0d op=%0d mw=%0d want 1 0 1", k, a_clear, a_op, a_modwait);
        end
        dr = 1'b1;
        @(negedge clk);
        dr = 1'b0;
        vectors++;
        if (a_clear !== 1'b1 || a_dest !== 4'd0 || a_modwait !== 1'b0) begin
          miscompares++;
          $display("FAIL wait2[%0d]: clr=%0d dest=%0d mw=%0d want 1 0 0", k, a_clear, a_dest, a_modwait);
        end
        lc = 1'b1;
      end
    end
    @(negedge clk);
    vectors++;
    if (a_clear !== 1'b0 || a_modwait !== 1'b1 || a_op !== 3'b000) begin
      miscompares++;
      $display("FAIL load_done: clr=%0d mw=%0d op=%0d want 0 1 0", a_clear, a_modwait, a_op);
    end
    @(negedge clk);
    vectors++;
    if (a_modwait !== 1'b0 || a_clear !== 1'b0) begin
      miscompares++;
      $display("FAIL load_idle: mw=%0d clr=%0d want 0 0", a_modwait, a_clear);
    end
  endtask

  // Full 4-tap sample: 14-cycle control sequence, add/sub per mask, modwait length.
  task automatic test_sample();
    int mw_cnt;
    mw_cnt = 0;
    dr = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 1) dr = 1'b0;
      if (a_modwait === 1'b1) mw_cnt++;
      vectors++;
      if (int'(a_dest) != dest4[i] || int'(a_op) != op4[i] || int'(a_src1) != s1_4[i] ||
          int'(a_src2) != s2_4[i] || int'(a_tap) != tap4[i] || a_cnt_up !== 1'(i == 1) ||
          a_err !== 1'b0 || a_clear !== 1'b0) begin
        miscompares++;
        $display("FAIL sample[%0d]: d=%0d op=%0d s1=%0d s2=%0d tap=%0d cu=%0d want %0d %0d %0d %0d %0d %0d",
                 i, a_dest, a_op, a_src1, a_src2, a_tap, a_cnt_up,
                 dest4[i], op4[i], s1_4[i], s2_4[i], tap4[i], (i == 1));
      end
    end
    for (int i = 14; i < 16; i++) begin
      @(negedge clk);
      if (a_modwait === 1'b1) mw_cnt++;
    end
    vectors++;
    if (a_op !== 3'b000 || a_dest !== 4'd0 || a_modwait !== 1'b0) begin
      miscompares++;
      $display("FAIL sample_idle: op=%0d dest=%0d mw=%0d want 0 0 0", a_op, a_dest, a_modwait);
    end
    vectors++;
    if (mw_cnt != 14) begin
      miscompares++;
      $display("FAIL sample_modwait_len: got %0d want 14", mw_cnt);
    end
  endtask

  // Overflow ignored in SHIFT, honoured in the second MUL; then a clean restart.
  task automatic test_overflow();
    dr = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) dr = 1'b0;
      if (i == 3) overflow = 1'b1;
      if (i == 4) begin
        overflow = 1'b0;
        vectors++;
        if (a_dest !== 4'd3 || a_op !== 3'b001 || a_err !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_ignored: dest=%0d op=%0d err=%0d want 3 1 0", a_dest, a_op, a_err);
        end
      end
    end
    vectors++;
    if (a_dest !== 4'd10 || a_op !== 3'b110 || a_tap !== 3'd1 || a_src2 !== 4'd7) begin
      miscompares++;
      $display("FAIL ovf_mul1: dest=%0d op=%0d tap=%0d s2=%0d want 10 6 1 7", a_dest, a_op, a_tap, a_src2);
    end
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    vectors++;
    if (a_err !== 1'b1 || a_modwait !== 1'b1 || a_op !== 3'b000) begin
      miscompares++;
      $display("FAIL ovf_eidle: err=%0d mw=%0d op=%0d want 1 1 0", a_err, a_modwait, a_op);
    end
    @(negedge clk);
    vectors++;
    if (a_err !== 1'b1 || a_modwait !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_mw_fall: err=%0d mw=%0d want 1 0", a_err, a_modwait);
    end
    dr = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_dest !== 4'd5 || a_op !== 3'b010 || a_err !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_store: dest=%0d op=%0d err=%0d want 5 2 0", a_dest, a_op, a_err);
    end
    @(negedge clk);
    dr = 1'b0;
    vectors++;
    if (a_cnt_up !== 1'b1 || a_op !== 3'b101 || a_dest !== 4'd0) begin
      miscompares++;
      $display("FAIL restart_zero: cu=%0d op=%0d dest=%0d want 1 5 0", a_cnt_up, a_op, a_dest);
    end
    @(negedge clk);
    vectors++;
    if (a_dest !== 4'd1 || a_src1 !== 4'd2 || a_tap !== 3'd1 || a_op !== 3'b001) begin
      miscompares++;
      $display("FAIL restart_shift: dest=%0d s1=%0d tap=%0d op=%0d want 1 2 1 1", a_dest, a_src1, a_tap, a_op);
    end
    repeat (12) @(negedge clk);
    vectors++;
    if (a_op !== 3'b000 || a_modwait !== 1'b1 || a_err !== 1'b0 || a_dest !== 4'd0) begin
      miscompares++;
      $display("FAIL restart_done: op=%0d mw=%0d err=%0d dest=%0d want 0 1 0 0", a_op, a_modwait, a_err, a_dest);
    end
  endtask

  // Reset asserted mid-SHIFT clears outputs at once; next sample starts from k=0.
  task automatic test_async_reset();
    dr = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) dr = 1'b0;
    end
    vectors++;
    if (a_tap !== 3'd2 || a_dest !== 4'd2) begin
      miscompares++;
      $display("FAIL rst_pre_shift: tap=%0d dest=%0d want 2 2", a_tap, a_dest);
    end
    #2 n_rst = 1'b0;
    #1;
    vectors++;
    if ({a_cnt_up, a_clear, a_modwait, a_err, a_op, a_src1, a_src2, a_dest, a_tap} !== 21'd0) begin
      miscompares++;
      $display("FAIL rst_async: got %h want 0",
               {a_cnt_up, a_clear, a_modwait, a_err, a_op, a_src1, a_src2, a_dest, a_tap});
    end
    @(negedge clk);
    n_rst = 1'b1;
    dr = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_dest !== 4'd5 || a_tap !== 3'd0 || a_modwait !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_store: dest=%0d tap=%0d mw=%0d want 5 0 0", a_dest, a_tap, a_modwait);
    end
    @(negedge clk);
    dr = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_dest !== 4'd1 || a_tap !== 3'd1 || a_op !== 3'b001) begin
      miscompares++;
      $display("FAIL rst_shift1: dest=%0d tap=%0d op=%0d want 1 1 1", a_dest, a_tap, a_op);
    end
  endtask

  // 6-tap instance: temp R14, coefficients R8..R13, only tap 0 subtracts, 20-cycle latency.
  task automatic test_taps6();
    int mw_cnt;
    mw_cnt = 0;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    dr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) dr = 1'b0;
      if (b_modwait === 1'b1) mw_cnt++;
      vectors++;
      if (int'(b_dest) != dest6[i] || int'(b_op) != op6[i] || int'(b_src2) != s2_6[i]) begin
        miscompares++;
        $display("FAIL taps6[%0d]: dest=%0d op=%0d s2=%0d want %0d %0d %0d",
                 i, b_dest, b_op, b_src2, dest6[i], op6[i], s2_6[i]);
      end
    end
    @(negedge clk);
    if (b_modwait === 1'b1) mw_cnt++;
    vectors++;
    if (b_op !== 3'b000 || b_dest !== 4'd0 || b_modwait !== 1'b1) begin
      miscompares++;
      $display("FAIL taps6_idle: op=%0d dest=%0d mw=%0d want 0 0 1", b_op, b_dest, b_modwait);
    end
    @(negedge clk);
    if (b_modwait === 1'b1) mw_cnt++;
    vectors++;
    if (mw_cnt != 20) begin
      miscompares++;
      $display("FAIL taps6_latency: modwait cycles %0d want 20", mw_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_rst       = 1'b0;
    dr          = 1'b0;
    lc          = 1'b0;
    overflow    = 1'b0;
    test_reset();
    test_dr_pulse();
    test_coef_load();
    test_sample();
    test_overflow();
    test_async_reset();
    test_taps6();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
